scene_sequencer: RTL and testbench

SCENE_SEQUENCER -- requirements
Module: scene_sequencer

---
 rtl/scene_sequencer.sv | 177 +++++++++++++++++
 tb/tb_scene_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scene_sequencer.sv
// rtl/scene_sequencer.sv - demo scene sequencer: per-frame scroll, fade out/in scene transitions, PRNG noise gating
module scene_sequencer #(
    parameter int NUM_SCENES       = 4,
    parameter int SCENE_FRAMES     = 240,
    parameter int FADE_STEP_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       pause,
    input  logic       skip,
    input  logic [7:0] noise_cfg,
    input  logic [7:0] prng_in,
    output logic [1:0] scene,
    output logic [9:0] scroll,
    output logic [1:0] fade,
    output logic [7:0] noise_mask,
    output logic       busy,
    output logic       frame_tick
);

    localparam logic [9:0] FRAME_LAST = 10'(SCENE_FRAMES - 1);
    localparam logic [7:0] STEP_LAST  = 8'(FADE_STEP_FRAMES - 1);
    localparam logic [1:0] SCENE_LAST = 2'(NUM_SCENES - 1);

    typedef enum logic [1:0] {
        ST_PLAY     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_SWITCH   = 2'd2,
        ST_FADE_IN  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_vs_d;
    logic        r_skip_d;
    logic        r_frame_tick;
    logic [1:0]  r_scene;
    logic [9:0]  r_scroll;
    logic [1:0]  r_fade;
    logic [9:0]  r_frame_cnt;
    logic [7:0]  r_step_cnt;
    logic [7:0]  r_noise_mask;

    logic        w_skip_edge;
    logic [1:0]  w_scene_next;
    logic [9:0]  w_scroll_next;
    logic [1:0]  w_fade_next;
    logic [9:0]  w_frame_cnt_next;
    logic [7:0]  w_step_cnt_next;

    // Skip acts on the same clock its rising edge is seen; only PLAY listens, so edges elsewhere are dropped
    assign w_skip_edge = skip & ~r_skip_d;

    // Edge-detect history; during reset the history tracks the live inputs so release never looks like an edge
    always_ff @(posedge clk) begin
        r_vs_d   <= vsync;
        r_skip_d <= skip;
        if (reset) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= vsync & ~r_vs_d;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_PLAY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and next-datapath values; everything holds unless a frame tick or skip edge moves it
    always_comb begin
        w_state_next     = r_state;
        w_scene_next     = r_scene;
        w_scroll_next    = r_scroll;
        w_fade_next      = r_fade;
        w_frame_cnt_next = r_frame_cnt;
        w_step_cnt_next  = r_step_cnt;
        case (r_state)
            ST_PLAY: begin
                if (w_skip_edge) begin
                    // Skip beats a coincident tick: no scroll advance on that tick
                    w_state_next     = ST_FADE_OUT;
                    w_frame_cnt_next = 10'd0;
                    w_step_cnt_next  = 8'd0;
                end else if (r_frame_tick && !pause) begin
                    w_scroll_next = r_scroll + 10'd1;
                    if (r_frame_cnt == FRAME_LAST) begin
                        w_state_next     = ST_FADE_OUT;
                        w_frame_cnt_next = 10'd0;
                        w_step_cnt_next  = 8'd0;
                    end else begin
                        w_frame_cnt_next = r_frame_cnt + 10'd1;
                    end
                end
            end
            ST_FADE_OUT: begin
                if (r_frame_tick) begin
                    if (r_step_cnt == STEP_LAST) begin
                        w_step_cnt_next = 8'd0;
                        w_fade_next     = r_fade + 2'd1;
                        if (r_fade == 2'd2) begin
                            w_state_next = ST_SWITCH;
                        end
                    end else begin
                        w_step_cnt_next = r_step_cnt + 8'd1;
                    end
                end
            end
            ST_SWITCH: begin
                // Screen is fully black here, so the scene swap and scroll rewind are invisible
                w_state_next    = ST_FADE_IN;
                w_scene_next    = (r_scene == SCENE_LAST) ? 2'd0 : r_scene + 2'd1;
                w_scroll_next   = 10'd0;
                w_step_cnt_next = 8'd0;
            end
            ST_FADE_IN: begin
                if (r_frame_tick) begin
                    if (r_step_cnt == STEP_LAST) begin
                        w_step_cnt_next = 8'd0;
                        w_fade_next     = r_fade - 2'd1;
                        if (r_fade == 2'd1) begin
                            w_state_next     = ST_PLAY;
                            w_frame_cnt_next = 10'd0;
                        end
                    end else begin
                        w_step_cnt_next = r_step_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_PLAY;
            end
        endcase
    end

    // Datapath registers; reset wins so an aborted SWITCH never advances the scene
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scene     <= 2'd0;
            r_scroll    <= 10'd0;
            r_fade      <= 2'd0;
            r_frame_cnt <= 10'd0;
            r_step_cnt  <= 8'd0;
        end else begin
            r_scene     <= w_scene_next;
            r_scroll    <= w_scroll_next;
            r_fade      <= w_fade_next;
            r_frame_cnt <= w_frame_cnt_next;
            r_step_cnt  <= w_step_cnt_next;
        end
    end

    // Noise only reaches the pins while a scene is playing
    always_ff @(posedge clk) begin
        if (reset) begin
            r_noise_mask <= 8'h00;
        end else if (r_state == ST_PLAY) begin
            r_noise_mask <= prng_in & noise_cfg;
        end else begin
            r_noise_mask <= 8'h00;
        end
    end

    assign scene      = r_scene;
    assign scroll     = r_scroll;
    assign fade       = r_fade;
    assign noise_mask = r_noise_mask;
    assign frame_tick = r_frame_tick;
    assign busy       = (r_state != ST_PLAY);

endmodule

// File: tb/tb_scene_sequencer.sv
// tb/tb_scene_sequencer.sv - self-checking bench for scene_sequencer
module tb_scene_sequencer;

    localparam int NS  = 4;
    localparam int SF  = 4;
    localparam int FSF = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b0;
    logic       pause = 1'b0;
    logic       skip = 1'b0;
    logic [7:0] noise_cfg = 8'h00;
    logic [7:0] prng_in = 8'h00;
    logic [1:0] scene;
    logic [9:0] scroll;
    logic [1:0] fade;
    logic [7:0] noise_mask;
    logic       busy;
    logic       frame_tick;

    always #5 clk = ~clk;

    scene_sequencer #(
        .NUM_SCENES(NS),
        .SCENE_FRAMES(SF),
        .FADE_STEP_FRAMES(FSF)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .vsync(vsync),
        .pause(pause),
        .skip(skip),
        .noise_cfg(noise_cfg),
        .prng_in(prng_in),
        .scene(scene),
        .scroll(scroll),
        .fade(fade),
        .noise_mask(noise_mask),
        .busy(busy),
        .frame_tick(frame_tick)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        logic [1:0] scene;
        logic [9:0] scroll;
        logic [1:0] fade;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int sc, input int scr, input int fd, input int bz);
        exp_t e;
        e.tag    = tag;
        e.scene  = 2'(sc);
        e.scroll = 10'(scr);
        e.fade   = 2'(fd);
        e.busy   = 1'(bz);
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".scene"},  32'(scene),  32'(e.scene));
            check({e.tag, ".scroll"}, 32'(scroll), 32'(e.scroll));
            check({e.tag, ".fade"},   32'(fade),   32'(e.fade));
            check({e.tag, ".busy"},   32'(busy),   32'(e.busy));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One vsync pulse; the resulting frame_tick is acted on by the second edge
    task automatic tick(input string tag, input int sc, input int scr, input int fd, input int bz);
        push_exp(tag, sc, scr, fd, bz);
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        step();
        pop_cmp();
    endtask

    task automatic skip_pulse(input string tag, input int sc, input int scr, input int fd, input int bz);
        push_exp(tag, sc, scr, fd, bz);
        skip = 1'b1;
        step();
        skip = 1'b0;
        pop_cmp();
    endtask

    task automatic clk_exp(input string tag, input int sc, input int scr, input int fd, input int bz);
        push_exp(tag, sc, scr, fd, bz);
        step();
        pop_cmp();
    endtask

    // Full fade out, SWITCH clock, fade in; optional ignored skip after the first fade-in tick
    task automatic transition(input string tag, input int sc_from, input int scr, input int sc_to, input bit skip_in);
        for (int i = 0; i < 3 * FSF; i++) begin
            tick($sformatf("%s_out%0d", tag, i), sc_from, scr, (i + 1) / FSF, 1);
        end
        clk_exp({tag, "_switch"}, sc_to, 0, 3, 1);
        for (int i = 0; i < 3 * FSF; i++) begin
            tick($sformatf("%s_in%0d", tag, i), sc_to, 0, 3 - (i + 1) / FSF, (i != 3 * FSF - 1) ? 1 : 0);
            if (skip_in && i == 0) begin
                skip_pulse({tag, "_skip_in_fade"}, sc_to, 0, 3, 1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        step();
        step();
        check("rst.frame_tick", 32'(frame_tick), 32'd0);
        check("rst.noise_mask", 32'(noise_mask), 32'd0);
        push_exp("rst", 0, 0, 0, 0);
        pop_cmp();
        reset = 1'b0;
        step();

        // Scroll advances per tick; the SF-th tick starts the fade out
        vsync = 1'b1;
        step();
        check("tick_pulse_hi", 32'(frame_tick), 32'd1);
        vsync = 1'b0;
        step();
        check("tick_pulse_lo", 32'(frame_tick), 32'd0);
        check("play_t0.scroll", 32'(scroll), 32'd1);
        for (int i = 1; i < SF; i++) begin
            tick($sformatf("play_t%0d", i), 0, i + 1, 0, (i == SF - 1) ? 1 : 0);
        end

        // Fade out, switch to scene 1, fade in
        transition("tr1", 0, SF, 1, 1'b0);

        // Pause freezes scroll and frame count
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick($sformatf("pause_t%0d", i), 1, 0, 0, 0);
        end
        pause = 1'b0;
        for (int i = 0; i < SF - 1; i++) begin
            tick($sformatf("unpause_t%0d", i), 1, i + 1, 0, 0);
        end

        // Skip under pause; fades ignore pause; skip in FADE_IN ignored
        pause = 1'b1;
        skip_pulse("skip_paused", 1, SF - 1, 0, 1);
        transition("tr2", 1, SF - 1, 2, 1'b1);
        clk_exp("after_tr2", 2, 0, 0, 0);
        pause = 1'b0;

        // Skip coinciding with a frame tick: skip wins, no scroll advance
        tick("pre_coin", 2, 1, 0, 0);
        push_exp("coincide", 2, 1, 0, 1);
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        skip = 1'b1;
        step();
        skip = 1'b0;
        pop_cmp();
        transition("tr3", 2, 1, 3, 1'b0);

        // Scene wraps from the last scene back to 0
        skip_pulse("skip_wrap", 3, 0, 0, 1);
        transition("tr4", 3, 0, 0, 1'b0);

        // Scroll modulo wrap 1023 -> 0
        force u_dut.r_scroll = 10'd1023;
        #1;
        release u_dut.r_scroll;
        tick("scroll_wrap", 0, 0, 0, 0);

        // Noise gating
        noise_cfg = 8'h0F;
        prng_in   = 8'hA5;
        step();
        check("noise_play", 32'(noise_mask), 32'h05);
        skip_pulse("skip_noise", 0, 0, 0, 1);
        check("noise_edge", 32'(noise_mask), 32'h05);
        step();
        check("noise_busy", 32'(noise_mask), 32'h00);

        // Reset mid fade-out at fade=2
        for (int i = 0; i < 2 * FSF; i++) begin
            tick($sformatf("rfo_t%0d", i), 0, 0, (i + 1) / FSF, 1);
        end
        reset = 1'b1;
        clk_exp("rst_fade2", 0, 0, 0, 0);
        reset = 1'b0;
        step();

        // Reset during SWITCH must not advance the scene
        skip_pulse("skip_rsw", 0, 0, 0, 1);
        for (int i = 0; i < 3 * FSF; i++) begin
            tick($sformatf("rsw_t%0d", i), 0, 0, (i + 1) / FSF, 1);
        end
        reset = 1'b1;
        clk_exp("rst_switch", 0, 0, 0, 0);
        check("rst_switch.noise", 32'(noise_mask), 32'h00);

        // vsync held high across reset release produces no tick
        vsync = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        check("vs_hold_t0", 32'(frame_tick), 32'd0);
        step();
        check("vs_hold_t1", 32'(frame_tick), 32'd0);
        clk_exp("vs_hold", 0, 0, 0, 0);
        vsync = 1'b0;
        step();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
